// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 VGA raster timing generator running on the pixel clock.
//   The raster stays idle until the MMCM lock has been seen continuously
//   high for LOCK_WAIT synchronized samples. Any loss of lock drops the
//   raster straight back to idle.
//
// Ports
//   clk_in1     in   pixel clock, rising edge
//   reset       in   synchronous, active-high reset
//   locked      in   MMCM lock status (asynchronous, synchronized here)
//   hsync       out  horizontal sync, active level SYNC_POL
//   vsync       out  vertical sync, active level SYNC_POL
//   video_on    out  pixel is inside the visible region
//   pixel_x     out  horizontal count, 0..H_TOTAL-1
//   pixel_y     out  vertical count, 0..V_TOTAL-1
//   line_start  out  one-cycle pulse at pixel_x == 0 while running
//   frame_start out  one-cycle pulse at (0,0) while running
//   running     out  raster is active
//
// States
//   state      | meaning
//   WAIT_LOCK  | raster idle, qualifying lock (lock_cnt counts lk_s highs)
//   RUN        | raster counting, outputs decoded from the counters
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   LOCK_WAIT = 16
) (
  input  logic       clk_in1,
  input  logic       reset,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // lock_cnt only needs to reach LOCK_WAIT-1
  localparam int LCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           lk_meta_q, lk_s_q;
  logic [9:0]     x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           video_on_q, video_on_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic           running_q, running_d;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    x_d        = x_q;
    y_d        = y_q;

    unique case (state_q)
      WAIT_LOCK: begin
        x_d = '0;
        y_d = '0;
        if (lk_s_q) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = RUN;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      RUN: begin
        if (!lk_s_q) begin
          // lock lost: abandon the frame immediately
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
          x_d        = '0;
          y_d        = '0;
        end else if (x_q == H_MAX) begin
          x_d = '0;
          y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
        x_d        = '0;
        y_d        = '0;
      end
    endcase

    // Decode from the next-count values so registered outputs line up
    // with the registered counters.
    running_d     = (state_d == RUN);
    hsync_d       = (running_d && x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (running_d && y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = running_d && (x_d < H_VIS) && (y_d < V_VIS);
    line_start_d  = running_d && (x_d == 10'd0);
    frame_start_d = running_d && (x_d == 10'd0) && (y_d == 10'd0);
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q       <= WAIT_LOCK;
      lock_cnt_q    <= '0;
      lk_meta_q     <= 1'b0;
      lk_s_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      lk_meta_q     <= locked;
      lk_s_q        <= lk_meta_q;
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen, using a reduced raster so whole frames fit
// in a short run. A driver issues reset/locked each cycle and pushes the
// reference model's expected outputs; a monitor compares every cycle.
module tb_vga_timing_gen;

  localparam int   HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int   VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int   LW = 16;
  localparam logic SP = 1'b0;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       hsync, vsync, video_on, line_start, frame_start, running;
  logic [9:0] pixel_x, pixel_y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .LOCK_WAIT(LW)
  ) dut (
    .clk_in1(clk), .reset(reset), .locked(locked),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  // {running, hsync, vsync, video_on, line_start, frame_start, x, y}
  logic [25:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  bit started = 0;

  // Reference model: position kept as a linear pixel index within a frame.
  bit m_s1 = 0, m_s2 = 0, m_run = 0;
  int m_streak = 0;
  int m_p = 0;

  function automatic logic [25:0] model_out(bit run, int p);
    int x, y;
    logic hs, vs, vid;
    x = p % HT;
    y = p / HT;
    if (!run) return {1'b0, ~SP, ~SP, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    hs  = (x >= HA + HF && x < HA + HF + HS) ? SP : ~SP;
    vs  = (y >= VA + VF && y < VA + VF + VS) ? SP : ~SP;
    vid = (x < HA) && (y < VA);
    return {1'b1, hs, vs, vid, 1'(x == 0), 1'(x == 0 && y == 0), 10'(x), 10'(y)};
  endfunction

  task automatic step(input logic r, input logic l);
    bit lk_s;
    @(negedge clk);
    reset  = r;
    locked = l;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_streak = 0; m_p = 0;
    end else begin
      lk_s = m_s2;
      m_s2 = m_s1;
      m_s1 = l;
      if (!m_run) begin
        if (lk_s) begin
          m_streak++;
          if (m_streak == LW) begin
            m_run = 1; m_p = 0; m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (!lk_s) begin
        m_run = 0; m_p = 0; m_streak = 0;
      end else begin
        m_p = (m_p + 1) % FRAME;
      end
    end
    exp_q.push_back(model_out(m_run, m_p));
    started = 1;
  endtask

  // Keep locked high until the model shows the raster at (tx, ty).
  task automatic goto_pos(input int tx, input int ty);
    int n;
    n = 0;
    while (!(m_run && (m_p % HT) == tx && (m_p / HT) == ty) && n < FRAME + 100) begin
      step(1'b0, 1'b1);
      n++;
    end
    if (n >= FRAME + 100) begin
      checks++;
      $display("FAIL goto_pos timeout: position (%0d,%0d) not reached in %0d cycles", tx, ty, n);
    end
  endtask

  initial begin : monitor
    logic [25:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        checks++;
        a = {running, hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y};
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_empty t=%0t got %h, no expected entry", $time, a);
        end else begin
          e = exp_q.pop_front();
          if (a === e) passes++;
          else
            $display("FAIL outputs t=%0t got run=%b hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d required run=%b hs=%b vs=%b vid=%b ls=%b fs=%b x=%0d y=%0d",
                     $time, a[25], a[24], a[23], a[22], a[21], a[20], a[19:10], a[9:0],
                     e[25], e[24], e[23], e[22], e[21], e[20], e[19:10], e[9:0]);
        end
      end
    end
  end

  initial begin : driver
    int drop;
    repeat (5) step(1'b1, 1'b0);
    repeat (100) step(1'b0, 1'b0);
    // short lock, glitch, then steady lock through more than a frame
    repeat (10) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (FRAME + 600) step(1'b0, 1'b1);
    // loss of lock mid-frame, then relock
    goto_pos(30, 10);
    repeat (5) step(1'b0, 1'b0);
    repeat (FRAME + 200) step(1'b0, 1'b1);
    // reset while hsync and vsync are both active
    goto_pos(HA + HF + 2, VA + VF + 1);
    step(1'b1, 1'b1);
    repeat (1000) step(1'b0, 1'b1);
    // randomized lock dropouts, glitches and resets
    drop = 0;
    for (int i = 0; i < 20000; i++) begin
      if (drop == 0 && $urandom_range(0, 999) < 3) drop = $urandom_range(1, 30);
      if ($urandom_range(0, 3999) == 0) step(1'b1, $urandom_range(0, 1) == 1);
      else if (drop > 0) begin
        step(1'b0, 1'b0);
        drop--;
      end else step(1'b0, 1'b1);
    end
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
